// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage: DEPTH-entry circular buffer of LANES x WIDTH payload plus halt flag.
// Define PIPE_STAGE_STATS_EN to build the saturating stall_cnt / flush_cnt counters; otherwise both read 0.

module pipe_stage_lane #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [PW-1:0]    wr_ptr,
    input  logic [PW-1:0]    rd_ptr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge CLK) begin
        if (we) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
endmodule

module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH-1:0]       in_data,
    input  logic                         in_halt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*WIDTH-1:0]       out_data,
    output logic                         out_halt,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         halt_latched,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  flush_cnt
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]                  wr_ptr, rd_ptr;
    logic [DEPTH-1:0]               halt_mem;
    logic [LANES-1:0][WIDTH-1:0]    head_data;
    logic                           enq, deq;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = nRST && (count < CW'(DEPTH));
    assign out_valid = nRST && (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    // Head is zero-masked when empty so downstream never sees stale slots.
    assign out_data  = out_valid ? head_data : '0;
    assign out_halt  = out_valid && halt_mem[rd_ptr];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        pipe_stage_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_lane (
            .CLK    (CLK),
            .we     (enq && !flush),
            .wr_ptr (wr_ptr),
            .rd_ptr (rd_ptr),
            .wdata  (in_data[g*WIDTH +: WIDTH]),
            .rdata  (head_data[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (enq && !flush) halt_mem[wr_ptr] <= in_halt;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            halt_latched <= 1'b0;
        end else if (flush) begin
            // Flush wins over any handshake this cycle; halt_latched survives.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= bump(wr_ptr);
            if (deq) rd_ptr <= bump(rd_ptr);
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
            if (deq && out_halt) halt_latched <= 1'b1;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [32:0] flush_sum;
    assign flush_sum = {1'b0, flush_cnt} + 33'(count);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush) flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule
